// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with frame-aligned run control
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   ce           pixel clock enable (one pixel per clk with ce=1)
//   run          1 = generate frames, 0 = stop at the end of the current frame
//   hsync        horizontal sync, active level HS_POL
//   vsync        vertical sync, active level VS_POL
//   de           display enable for the presented position
//   pixel_x      presented column, 0..H_TOTAL-1
//   pixel_y      presented line, 0..V_TOTAL-1
//   line_start   one-clk strobe when x=0 is presented
//   frame_start  one-clk strobe when (0,0) is presented
//   busy         1 while generating frames

module vga_timing_gen #(
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0,
    parameter int CW     = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          run,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          busy
);

    localparam int H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_DISP + H_FP;
    localparam int HS_END   = H_DISP + H_FP + H_SYNC;
    localparam int VS_START = V_DISP + V_FP;
    localparam int VS_END   = V_DISP + V_FP + V_SYNC;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic          HS_ACT = (HS_POL != 0);
    localparam logic          VS_ACT = (VS_POL != 0);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    // Decode is done in int so that sync windows ending exactly at 2^CW
    // do not wrap when truncated to CW bits.
    function automatic logic de_at(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return (int'(x) < H_DISP) && (int'(y) < V_DISP);
    endfunction

    function automatic logic hs_at(input logic [CW-1:0] x);
        return ((int'(x) >= HS_START) && (int'(x) < HS_END)) ? HS_ACT : ~HS_ACT;
    endfunction

    function automatic logic vs_at(input logic [CW-1:0] y);
        return ((int'(y) >= VS_START) && (int'(y) < VS_END)) ? VS_ACT : ~VS_ACT;
    endfunction

    logic          at_eol;
    logic          at_eof;
    logic [CW-1:0] nx;
    logic [CW-1:0] ny;

    // Next position in raster order; from IDLE the counters already sit at
    // (0,0), so starting a frame is the same as presenting (0,0) directly.
    always_comb begin
        at_eol = (pixel_x == H_LAST);
        at_eof = at_eol && (pixel_y == V_LAST);
        nx     = at_eol ? '0 : pixel_x + 1'b1;
        ny     = pixel_y;
        if (at_eol) begin
            ny = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pixel_x     <= '0;
            pixel_y     <= '0;
            de          <= 1'b0;
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Strobes are one clk wide even when ce drops right after them.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce) begin
                if (state == IDLE) begin
                    if (run) begin
                        state       <= RUN;
                        pixel_x     <= '0;
                        pixel_y     <= '0;
                        de          <= de_at('0, '0);
                        hsync       <= hs_at('0);
                        vsync       <= vs_at('0);
                        line_start  <= 1'b1;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                    end
                end else if (at_eof && !run) begin
                    // run is only honoured here, so a frame is never truncated.
                    state   <= IDLE;
                    pixel_x <= '0;
                    pixel_y <= '0;
                    de      <= 1'b0;
                    hsync   <= ~HS_ACT;
                    vsync   <= ~VS_ACT;
                    busy    <= 1'b0;
                end else begin
                    pixel_x     <= nx;
                    pixel_y     <= ny;
                    de          <= de_at(nx, ny);
                    hsync       <= hs_at(nx);
                    vsync       <= vs_at(ny);
                    line_start  <= at_eol;
                    frame_start <= at_eof;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized bench for vga_timing_gen against a position-based raster model

module tb_vga_timing_gen;

    localparam int H_DISP = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
    localparam int V_DISP = 5, V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int HS_POL = 1, VS_POL = 0, CW = 4;
    localparam int HT = H_DISP + H_FP + H_SYNC + H_BP;   // 15
    localparam int VT = V_DISP + V_FP + V_SYNC + V_BP;   // 10
    localparam int FRAME = HT * VT;                      // 150

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce  = 1'b0;
    logic          run = 1'b0;
    logic          hsync, vsync, de, line_start, frame_start, busy;
    logic [CW-1:0] pixel_x, pixel_y;

    int n_chk  = 0;
    int n_fail = 0;

    vga_timing_gen #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .run(run),
        .hsync(hsync), .vsync(vsync), .de(de),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a running flag plus a linear raster index; everything else is
    // derived arithmetically from the index.
    bit m_run = 0;
    int m_p   = 0;
    bit m_ls  = 0;
    bit m_fs  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_p = 0; m_ls = 0; m_fs = 0;
        end else begin
            m_ls = 0; m_fs = 0;
            if (ce) begin
                if (!m_run) begin
                    if (run) begin m_run = 1; m_p = 0; m_ls = 1; m_fs = 1; end
                end else if (m_p == FRAME - 1) begin
                    m_p = 0;
                    if (run) begin m_ls = 1; m_fs = 1; end
                    else m_run = 0;
                end else begin
                    m_p++;
                    m_ls = (m_p % HT == 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        int ex, ey;
        bit ede, ehs, evs;
        ex  = m_run ? m_p % HT : 0;
        ey  = m_run ? m_p / HT : 0;
        ede = m_run && ex < H_DISP && ey < V_DISP;
        ehs = (m_run && ex >= H_DISP + H_FP && ex < H_DISP + H_FP + H_SYNC) ? 1'b1 : 1'b0;
        evs = (m_run && ey >= V_DISP + V_FP && ey < V_DISP + V_FP + V_SYNC) ? 1'b0 : 1'b1;
        check("pixel_x", int'(pixel_x), ex);
        check("pixel_y", int'(pixel_y), ey);
        check("de", int'(de), int'(ede));
        check("hsync", int'(hsync), int'(ehs));
        check("vsync", int'(vsync), int'(evs));
        check("line_start", int'(line_start), int'(m_ls));
        check("frame_start", int'(frame_start), int'(m_fs));
        check("busy", int'(busy), int'(m_run));
    end

    int tick_n = 0;
    int prev_x, prev_y;

    // One clk: remember what was presented, wait for the next falling edge
    // (outputs settled), then drive the inputs for the following rising edge.
    task automatic tick(input bit c, input bit r);
        prev_x = int'(pixel_x);
        prev_y = int'(pixel_y);
        @(negedge clk);
        #1;
        ce  = c;
        run = r;
        tick_n++;
    endtask

    // Measures clks between two frame_starts; mode 0: ce=1, mode 1: ce alternates.
    task automatic measure(input int mode, input int exp_period);
        int t, start, hs_cnt, vs_cnt, de_cnt;
        bit seen;
        seen = 0;
        for (t = 0; t < 4 * FRAME && !seen; t++) begin
            tick(mode == 0 ? 1'b1 : bit'(tick_n % 2), 1'b1);
            seen = frame_start;
        end
        check("first_frame_start_seen", int'(seen), 1);
        start = tick_n; seen = 0; hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
        for (t = 0; t < 4 * FRAME && !seen; t++) begin
            if (mode == 0) begin
                hs_cnt += int'(hsync == 1'b1);
                vs_cnt += int'(vsync == 1'b0);
                de_cnt += int'(de);
            end
            tick(mode == 0 ? 1'b1 : bit'(tick_n % 2), 1'b1);
            seen = frame_start;
        end
        check("frame_period", tick_n - start, exp_period);
        if (mode == 0) begin
            check("hsync_active_clks", hs_cnt, H_SYNC * VT);
            check("vsync_active_clks", vs_cnt, V_SYNC * HT);
            check("de_active_clks", de_cnt, H_DISP * V_DISP);
        end
    endtask

    initial begin
        bit ok;
        repeat (3) tick(1'b0, 1'b0);
        check("reset_x", int'(pixel_x), 0);
        check("reset_hsync", int'(hsync), 0);
        check("reset_vsync", int'(vsync), 1);
        check("reset_busy", int'(busy), 0);
        @(negedge clk); rst = 0;

        // First start presents (0,0)
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("start_x", int'(pixel_x), 0);
        check("start_y", int'(pixel_y), 0);
        check("start_fs", int'(frame_start), 1);
        check("start_ls", int'(line_start), 1);
        check("start_de", int'(de), 1);
        check("start_busy", int'(busy), 1);
        repeat (7) tick(1'b1, 1'b1);
        check("x7", int'(pixel_x), 7);
        check("de_x7", int'(de), 1);
        tick(1'b1, 1'b1);
        check("de_x8", int'(de), 0);

        measure(0, FRAME);
        measure(1, 2 * FRAME);

        // Random ce with run held high
        repeat (3 * FRAME) tick(bit'($urandom_range(0, 1)), 1'b1);

        // Drop run mid-frame: the frame must finish and no new frame starts
        ok = 0;
        for (int t = 0; t < 4 * FRAME && !ok; t++) begin
            tick(1'b1, 1'b1);
            ok = (pixel_y == 3);
        end
        check("reached_y3", int'(ok), 1);
        ok = 0;
        for (int t = 0; t < 2 * FRAME && !ok; t++) begin
            tick(1'b1, 1'b0);
            ok = !busy;
        end
        check("stopped", int'(ok), 1);
        check("stop_prev_x", prev_x, HT - 1);
        check("stop_prev_y", prev_y, VT - 1);
        check("stop_no_fs", int'(frame_start), 0);
        repeat (5) tick(bit'($urandom_range(0, 1)), 1'b0);
        check("idle_hold_busy", int'(busy), 0);

        // Restart, then async reset mid-frame
        tick(1'b1, 1'b1);
        ok = 0;
        for (int t = 0; t < 4 * FRAME && !ok; t++) begin
            tick(1'b1, 1'b1);
            ok = (pixel_y == 4 && pixel_x == 5);
        end
        check("reached_5_4", int'(ok), 1);
        #2 rst = 1;
        #1;
        check("rst_x", int'(pixel_x), 0);
        check("rst_y", int'(pixel_y), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_vsync", int'(vsync), 1);
        tick(1'b1, 1'b1);
        rst = 0;
        tick(1'b1, 1'b1);
        check("restart_fs", int'(frame_start), 1);
        check("restart_x", int'(pixel_x), 0);

        // Fully random ce/run traffic, run biased high
        repeat (2000) tick(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 7) != 0));

        tick(1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 640x480 sync block.
- Resolution, porches, sync widths and polarities are set by parameters.
- Pixel rate comes from a clock-enable input, so the block contains no PLL.
- Adds display-enable, line/frame strobes and a start/stop run control that only takes effect on frame boundaries. Feeds the pixel pipeline and the VGA pins.

Parameters:
H_DISP, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels after display, before sync)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_DISP, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CW, 12, counter/coordinate width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ce  in  1  pixel clock enable; one pixel per clk with ce=1
run  in  1  1 = generate frames; 0 = stop at the end of the current frame
hsync  out  1  horizontal sync, level per HS_POL
vsync  out  1  vertical sync, level per VS_POL
de  out  1  1 while the presented position is in the active area
pixel_x  out  CW  current column, 0..H_TOTAL-1
pixel_y  out  CW  current line, 0..V_TOTAL-1
line_start  out  1  one-clk strobe when a new line is presented (pixel_x=0)
frame_start  out  1  one-clk strobe when (0,0) is presented
busy  out  1  1 in RUN state

Behaviour:
- Reset is asynchronous and active-high. clk is the single clock. Other inputs are sampled only on clk edges with ce=1.
- Derived values: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP. V_TOTAL analogous.
- Reset values: pixel_x=0, pixel_y=0, de=0, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0, busy=0. State is IDLE.
- All outputs are registered and mutually coherent. hsync, vsync and de always describe the pixel_x/pixel_y currently presented, with zero skew between them.
- Decode for a presented position (x,y):
  - de = (x<H_DISP)&&(y<V_DISP).
  - hsync is active iff H_DISP+H_FP <= x < H_DISP+H_FP+H_SYNC.
  - vsync is active iff V_DISP+V_FP <= y < V_DISP+V_FP+V_SYNC, over the whole line.
- IDLE state:
  - Outputs hold at their reset values.
  - On a ce edge with run=1: go to RUN and present (0,0) with de=1, line_start=1, frame_start=1, busy=1.
- RUN state, on each ce edge:
  - x advances by 1. At x=H_TOTAL-1, x wraps to 0 and y advances. At y=V_TOTAL-1 with x wrapping, y wraps to 0.
  - line_start is asserted on every edge that presents x=0.
  - frame_start is asserted on every edge that presents (0,0).
- Run control:
  - run is sampled only on the edge leaving the last position (H_TOTAL-1, V_TOTAL-1).
  - If run=0 there: go to IDLE instead of wrapping. Outputs take reset values, busy=0, and no frame_start is issued.
  - Deasserting run mid-frame never truncates the frame.
- ce=0: all outputs hold, except line_start and frame_start, which clear on the next clk regardless of ce (strobes are exactly one clk wide).
- ce=1 continuously gives exactly H_TOTAL*V_TOTAL clks per frame. For defaults that is 800*525 = 420000.
- rst asserted mid-frame: immediate return to reset values. Restart requires ce with run=1 and begins at (0,0).
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. No values outside the legal range are reachable.

Test Plan:
- Reset then ce=1, run=1 -> first edge presents (0,0) with de=1, frame_start=1, line_start=1, busy=1. pixel_x=639 has de=1; pixel_x=640 has de=0.
- Defaults, ce=1 -> hsync=0 exactly for x=656..751 (96 clks). Line period is 800 clks. vsync=0 exactly for y=490..491 (1600 clks). frame_start period is 420000 clks.
- ce toggling 1/0 alternate clks -> frame period is 840000 clks. Strobes are still exactly 1 clk wide. Outputs are otherwise frozen on ce=0 cycles.
- run dropped at y=100 -> frame completes through (799,524). Next ce goes to IDLE (busy=0, de=0, syncs high) with no frame_start. run=1 restarts at (0,0).
- rst pulsed at (300,200) -> outputs immediately at reset values. Next ce with run=1 presents (0,0).
- Override H_DISP=800, H_FP=40, H_SYNC=128, H_BP=88, V_DISP=600, V_FP=1, V_SYNC=4, V_BP=23, HS_POL=1, VS_POL=1 -> line 1056 clks, hsync=1 for x=840..967, frame 1056*628 clks.
